// File: rtl/mul_div_unit.sv
// Iterative 32-bit MIPS multiply/divide unit with architectural HI/LO registers.
// 33 busy cycles per operation (32 iterations + sign fix); start while busy is ignored.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opd;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div_zero;

    logic        signed_op;
    logic        start_div;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_rem33;
    logic        div_ok;
    logic [31:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // op[0] selects the unsigned variant, op[1] selects divide.
    assign signed_op = ~op[0];
    assign start_div = op[1];
    assign a_mag     = (signed_op && in1[31]) ? (~in1 + 32'd1) : in1;
    assign b_mag     = (signed_op && in2[31]) ? (~in2 + 32'd1) : in2;

    // Shift-add: multiplier lives in acc[31:0], partial product grows in acc[63:32].
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Restoring divide: the shifted remainder needs 33 bits before the trial subtract.
    assign div_rem33 = {acc[63:32], acc[31]};
    assign div_ok    = (div_rem33 >= {1'b0, opd});
    assign div_diff  = div_rem33[31:0] - opd;
    assign div_next  = div_ok ? {div_diff, acc[30:0], 1'b1}
                              : {div_rem33[31:0], acc[30:0], 1'b0};

    assign prod_fix = neg_res ? (~acc + 64'd1) : acc;
    assign quot_fix = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
    assign rem_fix  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            acc      <= 64'd0;
            opd      <= 32'd0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        is_div   <= start_div;
                        neg_res  <= signed_op && (in1[31] ^ in2[31]);
                        neg_rem  <= signed_op && in1[31];
                        div_zero <= start_div && (in2 == 32'd0);
                        acc      <= {32'd0, (start_div ? a_mag : b_mag)};
                        opd      <= start_div ? b_mag : a_mag;
                        cnt      <= 5'd0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end else begin
                        // Divide by zero leaves the dividend in the remainder naturally.
                        hi <= rem_fix;
                        lo <= div_zero ? 32'hFFFF_FFFF : quot_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
